// File: rtl/result_display.sv
// Result buffer with button browsing and a multiplexed 4-digit hex seven-segment display.
// Optional RESULT_OVERWRITE_EN: a write into a full buffer replaces the oldest entry.
module result_display #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SCAN_DIV = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [31:0]                wr_data,
    output logic                       wr_ready,
    input  logic                       nxt_button,
    input  logic                       prv_button,
    input  logic                       half_button,
    input  logic                       clr_button,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [3:0]                 seg_an,
    output logic [7:0]                 seg_seg
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]         mem [DEPTH];
    logic [AW-1:0]       head_q, head_d, tail_q, tail_d, view_q, view_d;
    logic [CW-1:0]       count_q, count_d;
    logic                half_q, half_d;
    logic [SCAN_DIV-1:0] cnt_q;
    logic [3:0]          seg_an_q, seg_an_d;
    logic [7:0]          seg_seg_q, seg_seg_d;
    logic                accept;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

`ifdef RESULT_OVERWRITE_EN
    logic ovf_q, ovf_d;
    assign wr_ready = ~clr_button;
    assign overflow = ovf_q;
`else
    assign wr_ready = (count_q < FULL) & ~clr_button;
    assign overflow = 1'b0;
`endif

    assign accept = wr_valid & wr_ready;
    assign count  = count_q;
    assign seg_an  = seg_an_q;
    assign seg_seg = seg_seg_q;

    // Priority: clear, then accepted write, then browse/half; losers are dropped.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        view_d  = view_q;
        count_d = count_q;
        half_d  = half_q;
`ifdef RESULT_OVERWRITE_EN
        ovf_d   = ovf_q;
`endif
        if (clr_button) begin
            count_d = '0;
            head_d  = tail_q;
            view_d  = '0;
            half_d  = 1'b0;
`ifdef RESULT_OVERWRITE_EN
            ovf_d   = 1'b0;
`endif
        end else if (accept) begin
            tail_d = AW'(tail_q + 1'b1);
            half_d = 1'b0;
`ifdef RESULT_OVERWRITE_EN
            if (count_q == FULL) begin
                head_d = AW'(head_q + 1'b1);
                view_d = AW'(DEPTH - 1);
                ovf_d  = 1'b1;
            end else begin
                count_d = CW'(count_q + 1'b1);
                view_d  = AW'(count_q);
            end
`else
            count_d = CW'(count_q + 1'b1);
            view_d  = AW'(count_q);
`endif
        end else begin
            if (half_button) half_d = ~half_q;
            if (count_q != '0) begin
                if (nxt_button && !prv_button && (CW'(view_q) + 1'b1 < count_q))
                    view_d = AW'(view_q + 1'b1);
                else if (prv_button && !nxt_button && (view_q != '0))
                    view_d = AW'(view_q - 1'b1);
            end
        end
    end

    logic [1:0]    digit;
    logic [AW-1:0] rd_idx;
    logic [31:0]   entry;
    logic [15:0]   half_word;
    logic [3:0]    nib;

    assign digit     = cnt_q[SCAN_DIV-1 -: 2];
    assign rd_idx    = AW'(head_q + view_q);
    assign entry     = mem[rd_idx];
    assign half_word = half_q ? entry[31:16] : entry[15:0];
    assign nib       = 4'(half_word >> {digit, 2'b00});

    always_comb begin
        seg_an_d  = ~(4'b0001 << digit);
        seg_seg_d = 8'hBF;
        if (count_q != '0) begin
            seg_seg_d = hex7(nib);
            if (half_q && digit == 2'd0) seg_seg_d[7] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[tail_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            view_q    <= '0;
            count_q   <= '0;
            half_q    <= 1'b0;
            cnt_q     <= '0;
            seg_an_q  <= 4'b1111;
            seg_seg_q <= 8'hFF;
`ifdef RESULT_OVERWRITE_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            view_q    <= view_d;
            count_q   <= count_d;
            half_q    <= half_d;
            cnt_q     <= cnt_q + 1'b1;
            seg_an_q  <= seg_an_d;
            seg_seg_q <= seg_seg_d;
`ifdef RESULT_OVERWRITE_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display (DEPTH=4, SCAN_DIV=4); follows RESULT_OVERWRITE_EN if defined.
module tb_result_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        nxt_button = 1'b0, prv_button = 1'b0, half_button = 1'b0, clr_button = 1'b0;
    logic [2:0]  count;
    logic        overflow;
    logic [3:0]  seg_an;
    logic [7:0]  seg_seg;

    int n_vec = 0;
    int n_err = 0;

    result_display #(.DEPTH(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .nxt_button(nxt_button), .prv_button(prv_button), .half_button(half_button),
        .clr_button(clr_button), .count(count), .overflow(overflow),
        .seg_an(seg_an), .seg_seg(seg_seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scans one full display period; each sampled digit must carry its expected pattern.
    task automatic chk_disp(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] exp_seg [4];
        logic [3:0] seen;
        int d;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        seen = '0;
        tick();
        for (int c = 0; c < 16; c++) begin
            tick();
            case (seg_an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (d < 0) begin
                chk({tag, "_an"}, {28'd0, seg_an}, 32'h0000000E);
            end else begin
                chk($sformatf("%s_dig%0d", tag, d), {24'd0, seg_seg}, {24'd0, exp_seg[d]});
                seen[d] = 1'b1;
            end
        end
        chk({tag, "_seen"}, {28'd0, seen}, 32'h0000000F);
    endtask

    task automatic write(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse(input logic n, input logic p, input logic h);
        nxt_button  = n;
        prv_button  = p;
        half_button = h;
        tick();
        nxt_button  = 1'b0;
        prv_button  = 1'b0;
        half_button = 1'b0;
    endtask

    task automatic clear();
        clr_button = 1'b1;
        tick();
        clr_button = 1'b0;
    endtask

    initial begin
        // Reset, then a second reset asserted mid-scan
        tick();
        rst = 1'b1;
        repeat (6) tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_an_async", {28'd0, seg_an}, 32'hF);
        chk("rst_seg_async", {24'd0, seg_seg}, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_an", {28'd0, seg_an}, 32'hF);
            chk("rst_seg", {24'd0, seg_seg}, 32'hFF);
            chk("rst_count", {29'd0, count}, 32'd0);
            chk("rst_ready", {31'd0, wr_ready}, 32'd1);
            chk("rst_ovf", {31'd0, overflow}, 32'd0);
        end
        rst = 1'b1;
        chk_disp("empty", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        // Lower/upper half display
        write(32'h1234ABCD);
        chk("disp_count", {29'd0, count}, 32'd1);
        chk_disp("lower", 8'h88, 8'h83, 8'hC6, 8'hA1);
        pulse(1'b0, 1'b0, 1'b1);
        chk_disp("upper", 8'hF9, 8'hA4, 8'hB0, 8'h19);
        clear();
        chk("clr_count", {29'd0, count}, 32'd0);

        // Fill and behaviour when full
        write(32'h11); write(32'h22); write(32'h33); write(32'h44);
        chk("full_count", {29'd0, count}, 32'd4);
        chk_disp("full_newest", 8'hC0, 8'hC0, 8'h99, 8'h99);
        wr_valid = 1'b1;
        wr_data  = 32'h55;
        #1;
`ifdef RESULT_OVERWRITE_EN
        chk("full_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        chk("ovw_count", {29'd0, count}, 32'd4);
        chk("ovw_ovf", {31'd0, overflow}, 32'd1);
        chk_disp("ovw_newest", 8'hC0, 8'hC0, 8'h92, 8'h92);
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        chk_disp("ovw_oldest", 8'hC0, 8'hC0, 8'hA4, 8'hA4);
        pulse(1'b0, 1'b1, 1'b0);
        chk_disp("ovw_prv_floor", 8'hC0, 8'hC0, 8'hA4, 8'hA4);
`else
        chk("full_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        wr_valid = 1'b0;
        chk("stall_count", {29'd0, count}, 32'd4);
        chk("stall_ovf", {31'd0, overflow}, 32'd0);
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        chk_disp("full_oldest", 8'hC0, 8'hC0, 8'hF9, 8'hF9);
        pulse(1'b0, 1'b1, 1'b0);
        chk_disp("full_prv_floor", 8'hC0, 8'hC0, 8'hF9, 8'hF9);
`endif

        // Clear colliding with a write
        clr_button = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 32'h99;
        #1;
        chk("coll_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        clr_button = 1'b0;
        wr_valid   = 1'b0;
        chk("coll_count", {29'd0, count}, 32'd0);
        chk("coll_ovf", {31'd0, overflow}, 32'd0);
        chk_disp("coll_disp", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        wr_valid = 1'b1;
        #1;
        chk("post_clr_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        chk("post_clr_count", {29'd0, count}, 32'd1);
        clear();

        // Write beats browse in the same cycle, then browse boundaries
        write(32'hA);
        wr_valid   = 1'b1;
        wr_data    = 32'hB;
        prv_button = 1'b1;
        tick();
        wr_valid   = 1'b0;
        prv_button = 1'b0;
        chk("wb_count", {29'd0, count}, 32'd2);
        chk_disp("wb_newest", 8'hC0, 8'hC0, 8'hC0, 8'h83);
        pulse(1'b0, 1'b1, 1'b0);
        chk_disp("wb_prv", 8'hC0, 8'hC0, 8'hC0, 8'h88);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk_disp("nxt_ceiling", 8'hC0, 8'hC0, 8'hC0, 8'h83);
        pulse(1'b1, 1'b1, 1'b0);
        chk_disp("nxt_prv_both", 8'hC0, 8'hC0, 8'hC0, 8'h83);
        pulse(1'b0, 1'b1, 1'b1);
        chk_disp("prv_half", 8'hC0, 8'hC0, 8'hC0, 8'h40);

        // Reset with data buffered discards it
        #2 rst = 1'b0;
        #1;
        chk("rst2_count", {29'd0, count}, 32'd0);
        chk("rst2_an", {28'd0, seg_an}, 32'hF);
        chk("rst2_seg", {24'd0, seg_seg}, 32'hFF);
        chk("rst2_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        chk_disp("rst2_disp", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Output-side counterpart of the button/number-entry front end: the CPU pushes 32-bit results out to the user through this block.
- Results are buffered in a small circular store; the user browses them with debounced button pulses.
- The selected 16-bit half of the selected entry is shown as 4 hex digits on the multiplexed seven-segment display.
- Sits between the CPU result path and the board seg_an/seg_seg pins.

Parameters:
- DEPTH, 4, number of result entries; power of 2, minimum 2.
- SCAN_DIV, 17, width of the free-running scan counter; digit index = cnt[SCAN_DIV-1:SCAN_DIV-2].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  CPU result valid.
- wr_data  in  32  CPU result word.
- wr_ready  out  1  block can accept a result this cycle.
- nxt_button  in  1  single-cycle pulse (already debounced): browse toward newer entry.
- prv_button  in  1  single-cycle pulse: browse toward older entry.
- half_button  in  1  single-cycle pulse: toggle upper/lower 16-bit half.
- clr_button  in  1  single-cycle pulse: empty the buffer.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: an entry was overwritten.
- seg_an  out  4  digit enables, active-low, one-hot.
- seg_seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst=0, async): seg_an=4'b1111, seg_seg=8'hFF, wr_ready=1, count=0, overflow=0, view=0, half=low, scan counter=0, pointers=0.
- Buffer: circular store with head (oldest) and tail (next write). view is an offset from head, range 0..count-1.
- Write accepted when wr_valid & wr_ready. Effects on the same clock edge: entry stored at tail, count+1, view set to newest (count-1 after the update), half set to low.
- wr_ready = (count<DEPTH) & ~clr_button. This is a combinational flag.
- Cycle priority: clr_button > accepted write > browse buttons. Lower-priority events in the same cycle are dropped, not queued.
- clr_button: count=0, head=tail, view=0, half=low, overflow=0. wr_ready is 0 during that cycle, so any simultaneous write is not accepted.
- nxt_button: view=min(view+1, count-1).
- prv_button: view=max(view-1, 0).
- nxt and prv in the same cycle: no change.
- half_button: toggles half. It is combinable with nxt/prv in the same cycle.
- Browse buttons with count=0: ignored.
- Display: scan counter increments every cycle and wraps. Digit d = cnt[SCAN_DIV-1:SCAN_DIV-2] drives seg_an = ~(1<<d).
- Digit 3 shows the most significant nibble of the selected half.
- Hex encoding (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- dp is lit (bit7=0) on digit 0 only while the upper half is shown.
- count=0: every digit shows '-' (8'hBF), no dp.
- seg_an and seg_seg are registered: they reflect scan/state with 1-cycle latency.
- Reset asserted mid-operation discards all buffered data immediately.

Optional Feature:
- Macro: RESULT_OVERWRITE_EN.
- Defined: wr_ready = ~clr_button. A write when count==DEPTH overwrites the oldest entry: head+1, count stays DEPTH, overflow set to 1, view set to newest.
- Undefined: writes stall while full (wr_ready=0); overflow is tied 0.

Test Plan (SCAN_DIV=4 for simulation):
- Reset: hold rst=0 for 3 cycles mid-scan -> seg_an=1111, seg_seg=FF, count=0, wr_ready=1. After release, all digits show BF.
- Display: write 32'h1234ABCD -> count=1; digits 3..0 show 88,83,C6,A1. Pulse half_button -> digits show F9,A4,B0,19 (digit 0 carries dp).
- Full without macro: write 11,22,33,44 -> count=4, wr_ready=0. A 5th wr_valid with 55 is not accepted; after 3 prv pulses the display shows 0011; a 4th prv leaves view=0.
- Overwrite with RESULT_OVERWRITE_EN: after the same 4 writes, write 55 -> accepted, count=4, overflow=1; after 3 prv pulses the display shows 0022.
- Clear collision: clr_button and wr_valid(99) in the same cycle -> wr_ready=0, count=0, overflow=0, display BF. Next-cycle write of 99 is accepted with count=1.
- Write vs browse: prv_button in the same cycle as an accepted write -> view equals the newest entry, prv ignored.
